user_proj_wb_example: RTL and testbench



---
 rtl/fann_wbs_pkg.sv | 30 +++
 rtl/node_ram.sv | 26 ++
 rtl/user_proj_wb_example.sv | 210 +++++++++++++++++++++
 tb/tb_user_proj_wb_example.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fann_wbs_pkg.sv
// Shared constants and types for the Fast-ANN Wishbone slave.
// Address map, node entry layout and sequencer states.
package fann_wbs_pkg;

    localparam logic [31:0] WBS_ADDR_MASK   = 32'hFFFF_0000;

    localparam logic [31:0] WBS_MODE_ADDR   = 32'h3000_0000;
    localparam logic [31:0] WBS_DEBUG_ADDR  = 32'h3000_0004;
    localparam logic [31:0] WBS_DONE_ADDR   = 32'h3000_0008;
    localparam logic [31:0] WBS_START_ADDR  = 32'h3000_000C;
    localparam logic [31:0] WBS_BUSY_ADDR   = 32'h3000_0010;

    localparam logic [31:0] WBS_QUERY_ADDR  = 32'h3001_0000;
    localparam logic [31:0] WBS_LEAF_ADDR   = 32'h3002_0000;
    localparam logic [31:0] WBS_BEST_ADDR   = 32'h3003_0000;
    localparam logic [31:0] WBS_NODE_ADDR   = 32'h3004_0000;

    localparam int NODE_DW = 11;

    typedef struct packed {
        logic [NODE_DW-1:0] median;
        logic [NODE_DW-1:0] index;
    } node_t;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_RUN
    } seq_state_e;

endpackage

// File: rtl/node_ram.sv
// KD-tree internal-node storage: 1 write / 1 read, sync write, async read.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o. No reset.
module node_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 22
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/user_proj_wb_example.sv
// Fast-ANN Wishbone slave: MODE/DEBUG/DONE/START/BUSY regs, node RAM,
// fixed-length run sequencer; status on io_out[31:30], la_data_out, irq[0].
// Ports: wb_clk_i, rst_n (async low), wbs_* slave bus, la_*, io_*, irq.
// Option: NODE_READBACK_EN makes NODE reads return the stored entry.
import fann_wbs_pkg::*;

module user_proj_wb_example #(
    parameter int BITS       = 32,
    parameter int DATA_WIDTH = NODE_DW,
    parameter int NUM_LEAVES = 64,
    parameter int ADDR_WIDTH = $clog2(NUM_LEAVES),
    parameter int FSM_CYCLES = 16
) (
    input  logic            wb_clk_i,
    input  logic            rst_n,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [BITS-1:0] wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [BITS-1:0] wbs_dat_o,
    input  logic [127:0]    la_data_in,
    input  logic [127:0]    la_oenb,
    output logic [127:0]    la_data_out,
    input  logic [37:0]     io_in,
    output logic [37:0]     io_out,
    output logic [37:0]     io_oeb,
    output logic [2:0]      irq
);

    localparam int CNT_W = (FSM_CYCLES > 1) ? $clog2(FSM_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FSM_CYCLES - 1);
    localparam int NW = 2 * DATA_WIDTH;

    logic            req;
    logic            ack_q, ack_d;
    logic            bus_wr;
    logic [31:0]     region;
    logic            hit_mode, hit_debug, hit_done;
    logic            hit_start, hit_busy, hit_node;

    logic [1:0]      mode_q, mode_d;
    logic            debug_q, debug_d;
    logic            done_q, done_d;
    logic            start_q, start_d;
    logic            irq_q, irq_d;

    seq_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            seq_fin;
    logic            busy;

    node_t           wr_node;
    logic [NW-1:0]   rd_node;
    logic            node_wr;
    logic [BITS-1:0] rdata;

    assign req    = wbs_cyc_i & wbs_stb_i;
    assign ack_d  = req & ~ack_q;
    // Writes commit on the edge that raises ack, so one per transaction.
    assign bus_wr = req & ~ack_q & wbs_we_i;

    assign region    = wbs_adr_i & WBS_ADDR_MASK;
    assign hit_mode  = (wbs_adr_i == WBS_MODE_ADDR);
    assign hit_debug = (wbs_adr_i == WBS_DEBUG_ADDR);
    assign hit_done  = (wbs_adr_i == WBS_DONE_ADDR);
    assign hit_start = (wbs_adr_i == WBS_START_ADDR);
    assign hit_busy  = (wbs_adr_i == WBS_BUSY_ADDR);
    assign hit_node  = (region == WBS_NODE_ADDR);

    assign busy = (state_q == SEQ_RUN);

    always_comb begin
        mode_d  = mode_q;
        debug_d = debug_q;
        done_d  = done_q;
        start_d = 1'b0;
        irq_d   = seq_fin;
        if (bus_wr && hit_mode && !busy) begin
            mode_d = wbs_dat_i[1:0];
        end
        if (bus_wr && hit_debug) begin
            debug_d = wbs_dat_i[0];
        end
        if (bus_wr && hit_done && wbs_dat_i[0]) begin
            done_d = 1'b0;
        end
        // A finishing run beats a simultaneous W1C clear.
        if (seq_fin) begin
            done_d = 1'b1;
        end
        if (bus_wr && hit_start && wbs_dat_i[0]
            && !busy && !start_q) begin
            start_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            mode_q  <= 2'b00;
            debug_q <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            mode_q  <= mode_d;
            debug_q <= debug_d;
            done_q  <= done_d;
            start_q <= start_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seq_fin = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (start_q) begin
                    state_d = SEQ_RUN;
                    cnt_d   = CNT_LOAD;
                end
            end
            SEQ_RUN: begin
                if (cnt_q == '0) begin
                    state_d = SEQ_IDLE;
                    seq_fin = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign node_wr        = bus_wr && hit_node && !busy;
    assign wr_node.median = wbs_dat_i[NW-1:DATA_WIDTH];
    assign wr_node.index  = wbs_dat_i[DATA_WIDTH-1:0];

    node_ram #(
        .DEPTH (NUM_LEAVES),
        .AW    (ADDR_WIDTH),
        .DW    (NW)
    ) u_node_ram (
        .clk_i   (wb_clk_i),
        .we_i    (node_wr),
        .waddr_i (wbs_adr_i[ADDR_WIDTH-1:0]),
        .wdata_i (wr_node),
        .raddr_i (wbs_adr_i[ADDR_WIDTH-1:0]),
        .rdata_o (rd_node)
    );

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            hit_mode:  rdata[1:0] = mode_q;
            hit_debug: rdata[0]   = debug_q;
            hit_done:  rdata[0]   = done_q;
            hit_busy:  rdata[0]   = busy;
`ifdef NODE_READBACK_EN
            hit_node:  rdata[NW-1:0] = rd_node;
`endif
            default: ;
        endcase
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = ack_q ? rdata : '0;

    always_comb begin
        io_out      = '0;
        io_out[31]  = done_q;
        io_out[30]  = busy;
        io_oeb      = '1;
        io_oeb[31]  = 1'b0;
        io_oeb[30]  = 1'b0;
        la_data_out = '0;
        la_data_out[3:0] = {busy, done_q, debug_q, mode_q[0]};
        la_data_out[5:4] = mode_q;
    end

    assign irq = {2'b00, irq_q};

    logic unused_ok;
`ifdef NODE_READBACK_EN
    assign unused_ok = &{1'b0, wbs_sel_i, la_data_in, la_oenb, io_in,
                         wbs_dat_i[BITS-1:NW]};
`else
    assign unused_ok = &{1'b0, wbs_sel_i, la_data_in, la_oenb, io_in,
                         wbs_dat_i[BITS-1:NW], rd_node};
`endif

endmodule

// File: tb/tb_user_proj_wb_example.sv
// Directed self-checking bench for user_proj_wb_example.
// Covers bus timing, registers, node RAM, sequencer, reset.
module tb_user_proj_wb_example;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stb, cyc, we;
    logic [3:0]   sel;
    logic [31:0]  adr, dat_i;
    logic         ack;
    logic [31:0]  dat_o;
    logic [127:0] la_in, la_oenb, la_out;
    logic [37:0]  io_in, io_out, io_oeb;
    logic [2:0]   irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    user_proj_wb_example dut (
        .wb_clk_i    (clk),
        .rst_n       (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_i),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .la_data_in  (la_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_out),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .irq         (irq)
    );

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd);
        bit ok;
        ok = 1'b0;
        rd = '0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                ok = 1'b1;
                rd = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bus_ack adr=%h got no ack, want ack", a);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        xfer(1'b1, a, d, rd);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        stb = 0; cyc = 0; we = 0; sel = 4'hF;
        adr = '0; dat_i = '0;
        la_in = '0; la_oenb = '1; io_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ack !== 1'b0 || dat_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus ack=%b dat=%h want 0/0", ack, dat_o);
        end
        tests++;
        if (io_out !== 38'h0 || irq !== 3'b000) begin
            fails++;
            $display("FAIL reset_status io=%h irq=%b want 0", io_out, irq);
        end
        tests++;
        if (io_oeb !== 38'h3F_3FFF_FFFF) begin
            fails++;
            $display("FAIL reset_oeb got %h want 3f3fffffff", io_oeb);
        end
        tests++;
        if (la_out !== 128'h0) begin
            fails++;
            $display("FAIL reset_la got %h want 0", la_out);
        end
    endtask

    task automatic test_held_write;
        logic [4:0] pat;
        logic [31:0] rd;
        @(negedge clk);
        cyc = 1; stb = 1; we = 1;
        adr = 32'h3000_0004; dat_i = 32'h1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            pat[4-i] = ack;
        end
        cyc = 0; stb = 0; we = 0;
        tests++;
        if (pat !== 5'b10101) begin
            fails++;
            $display("FAIL held_ack_pattern got %b want 10101", pat);
        end
        xfer(1'b0, 32'h3000_0004, '0, rd);
        tests++;
        if (rd !== 32'h1) begin
            fails++;
            $display("FAIL debug_read got %h want 1", rd);
        end
        tests++;
        if (la_out[1] !== 1'b1) begin
            fails++;
            $display("FAIL la_debug got %b want 1", la_out[1]);
        end
    endtask

    task automatic test_node;
        logic [31:0] rd, e1, e2, e0;
`ifdef NODE_READBACK_EN
        e1 = 32'h0001_B801;
        e2 = 32'h0000_383F;
        e0 = 32'h0000_0005;
`else
        e1 = 32'h0;
        e2 = 32'h0;
        e0 = 32'h0;
`endif
        wr(32'h3004_0001, {10'b0, 11'd55, 11'd1});
        wr(32'h3004_003F, {10'h3FF, 11'd7, 11'd63});
        wr(32'h3004_0040, 32'h5);
        xfer(1'b0, 32'h3004_0001, '0, rd);
        tests++;
        if (rd !== e1) begin
            fails++;
            $display("FAIL node1_read got %h want %h", rd, e1);
        end
        xfer(1'b0, 32'h3004_003F, '0, rd);
        tests++;
        if (rd !== e2) begin
            fails++;
            $display("FAIL node63_read got %h want %h", rd, e2);
        end
        xfer(1'b0, 32'h3004_0000, '0, rd);
        tests++;
        if (rd !== e0) begin
            fails++;
            $display("FAIL node0_alias got %h want %h", rd, e0);
        end
    endtask

    task automatic test_fsm;
        logic [31:0] rd, e1;
        int busy_cnt, irq_cnt;
        bit fall_ok, irq_ok;
        logic prev;
`ifdef NODE_READBACK_EN
        e1 = 32'h0001_B801;
`else
        e1 = 32'h0;
`endif
        wr(32'h3000_0000, 32'h2);
        xfer(1'b0, 32'h3000_0000, '0, rd);
        tests++;
        if (rd !== 32'h2 || la_out[5:4] !== 2'b10) begin
            fails++;
            $display("FAIL mode_write got %h la=%b want 2", rd, la_out[5:4]);
        end
        wr(32'h3000_000C, 32'h1);
        tests++;
        if (io_out[30] !== 1'b0) begin
            fails++;
            $display("FAIL busy_early got %b want 0", io_out[30]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (io_out[30] !== 1'b1) begin
            fails++;
            $display("FAIL busy_rise got %b want 1", io_out[30]);
        end
        busy_cnt = 0; irq_cnt = 0;
        fall_ok = 1; irq_ok = 1; prev = 1'b1;
        fork
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    busy_cnt += int'(io_out[30]);
                    if (irq[0]) begin
                        irq_cnt++;
                        if (io_out[31] !== 1'b1 || io_out[30] !== 1'b0)
                            irq_ok = 0;
                    end
                    if (prev && !io_out[30] && io_out[31] !== 1'b1)
                        fall_ok = 0;
                    prev = io_out[30];
                end
            end
            begin
                wr(32'h3000_000C, 32'h1);
                wr(32'h3000_0000, 32'h1);
                wr(32'h3004_0001, 32'h123);
            end
        join
        tests++;
        if (busy_cnt != 16) begin
            fails++;
            $display("FAIL busy_cycles got %0d want 16", busy_cnt);
        end
        tests++;
        if (irq_cnt != 1 || !irq_ok) begin
            fails++;
            $display("FAIL irq_pulse got %0d ok=%b want 1", irq_cnt, irq_ok);
        end
        tests++;
        if (!fall_ok || io_out[31] !== 1'b1) begin
            fails++;
            $display("FAIL done_at_fall ok=%b done=%b want 1", fall_ok, io_out[31]);
        end
        xfer(1'b0, 32'h3000_0000, '0, rd);
        tests++;
        if (rd !== 32'h2) begin
            fails++;
            $display("FAIL mode_locked got %h want 2", rd);
        end
        xfer(1'b0, 32'h3004_0001, '0, rd);
        tests++;
        if (rd !== e1) begin
            fails++;
            $display("FAIL node_locked got %h want %h", rd, e1);
        end
        xfer(1'b0, 32'h3000_0008, '0, rd);
        tests++;
        if (rd !== 32'h1 || la_out !== 128'h26) begin
            fails++;
            $display("FAIL done_read got %h la=%h want 1/26", rd, la_out);
        end
    endtask

    task automatic test_reset_midrun;
        logic [31:0] rd, e1;
`ifdef NODE_READBACK_EN
        e1 = 32'h0001_B801;
`else
        e1 = 32'h0;
`endif
        wr(32'h3000_000C, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (io_out[30] !== 1'b1 || io_out[31] !== 1'b1) begin
            fails++;
            $display("FAIL midrun_pre io=%b want 11", io_out[31:30]);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (io_out[31:30] !== 2'b00 || irq !== 3'b0 || la_out !== 128'h0) begin
            fails++;
            $display("FAIL midrun_reset io=%b irq=%b want 0", io_out[31:30], irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'h3004_0001, '0, rd);
        tests++;
        if (rd !== e1) begin
            fails++;
            $display("FAIL node_keep got %h want %h", rd, e1);
        end
    endtask

    task automatic test_done_clear;
        logic [31:0] rd;
        bit seen;
        wr(32'h3000_000C, 32'h1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (io_out[31] === 1'b1) begin
                seen = 1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL run_timeout done=%b want 1", io_out[31]);
        end
        wr(32'h3000_0008, 32'h0);
        xfer(1'b0, 32'h3000_0008, '0, rd);
        tests++;
        if (rd !== 32'h1) begin
            fails++;
            $display("FAIL done_w0 got %h want 1", rd);
        end
        wr(32'h3000_0008, 32'h1);
        xfer(1'b0, 32'h3000_0008, '0, rd);
        tests++;
        if (rd !== 32'h0 || io_out[31] !== 1'b0) begin
            fails++;
            $display("FAIL done_w1c got %h io=%b want 0", rd, io_out[31]);
        end
        wr(32'h3002_0010, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h3002_0010, '0, rd);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL leaf_read got %h want 0", rd);
        end
        xfer(1'b0, 32'h3000_000C, '0, rd);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL start_read got %h want 0", rd);
        end
        xfer(1'b0, 32'h3000_0010, '0, rd);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL busy_read got %h want 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_held_write();
        test_node();
        test_fsm();
        test_reset_midrun();
        test_done_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
